// File: rtl/tx_scheduler_pkg.sv
// rtl/tx_scheduler_pkg.sv - shared state encoding, default depth and FIFO entry type for the UART transmit path
package tx_scheduler_pkg;

    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } tx_entry_t;

endpackage

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - per-requester {last, data} FIFO with count-based full/empty
module tx_fifo
    import tx_scheduler_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  logic [8:0] entry_i,
    input  logic       pop_i,
    output logic [8:0] head_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    tx_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Guards make an overflowing push or an underflowing pop a no-op.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= tx_entry_t'(entry_i);
    end

endmodule

// File: rtl/tx_scheduler.sv
// rtl/tx_scheduler.sv - two-requester message-locked round-robin byte scheduler feeding a UART transmitter
module tx_scheduler
    import tx_scheduler_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] a_data,
    input  logic       a_last,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [7:0] b_data,
    input  logic       b_last,
    input  logic       b_valid,
    output logic       b_ready,
    output logic [7:0] txdata,
    output logic       send,
    input  logic       txdone,
    output logic       owner,
    output logic       busy
);

    tx_state_e   state_q, state_d;
    logic [7:0]  txdata_q, txdata_d;
    logic        send_q, send_d;
    logic        owner_q, owner_d;
    logic        lock_q, lock_d;
    logic        last_served_q, last_served_d;

    logic        a_full, a_empty, b_full, b_empty;
    logic [8:0]  a_head, b_head;
    tx_entry_t   head;
    logic        pop_a, pop_b;
    logic        elig_a, elig_b, pick_b;

    assign a_ready = reset && !a_full;
    assign b_ready = reset && !b_full;

    tx_fifo #(.DEPTH(DEPTH)) u_fifo_a (
        .clock   (clock),
        .reset   (reset),
        .push_i  (a_valid && a_ready),
        .entry_i ({a_last, a_data}),
        .pop_i   (pop_a),
        .head_o  (a_head),
        .full_o  (a_full),
        .empty_o (a_empty)
    );

    tx_fifo #(.DEPTH(DEPTH)) u_fifo_b (
        .clock   (clock),
        .reset   (reset),
        .push_i  (b_valid && b_ready),
        .entry_i ({b_last, b_data}),
        .pop_i   (pop_b),
        .head_o  (b_head),
        .full_o  (b_full),
        .empty_o (b_empty)
    );

    // While a message is open only its owner may be picked; otherwise the requester not served last wins ties.
    assign elig_a = !a_empty && (!lock_q || !owner_q);
    assign elig_b = !b_empty && (!lock_q ||  owner_q);
    assign pick_b = elig_b && (!elig_a || !last_served_q);
    assign head   = tx_entry_t'(pick_b ? b_head : a_head);

    always_comb begin
        state_d       = state_q;
        txdata_d      = txdata_q;
        send_d        = send_q;
        owner_d       = owner_q;
        lock_d        = lock_q;
        last_served_d = last_served_q;
        pop_a         = 1'b0;
        pop_b         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (elig_a || elig_b) begin
                    pop_a    = !pick_b;
                    pop_b    = pick_b;
                    txdata_d = head.data;
                    owner_d  = pick_b;
                    send_d   = 1'b1;
                    lock_d   = !head.last;
                    if (head.last) last_served_d = pick_b;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                // A txdone still high from the previous byte is stale until the transmitter drops it.
                if (!txdone) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (txdone) begin
                    send_d  = 1'b0;
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            txdata_q      <= '0;
            send_q        <= 1'b0;
            owner_q       <= 1'b0;
            lock_q        <= 1'b0;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            txdata_q      <= txdata_d;
            send_q        <= send_d;
            owner_q       <= owner_d;
            lock_q        <= lock_d;
            last_served_q <= last_served_d;
        end
    end

    assign txdata = txdata_q;
    assign send   = send_q;
    assign owner  = owner_q;
    assign busy   = (state_q != ST_IDLE) || !a_empty || !b_empty;

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, per-requester FIFO depth in entries (power of two, 2..16).
REQ-002 clock  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 a_data  input  8  requester A byte.
REQ-005 a_last  input  1  requester A byte ends a message.
REQ-006 a_valid  input  1  requester A byte present.
REQ-007 a_ready  output  1  requester A FIFO can accept.
REQ-008 b_data, b_last, b_valid, b_ready  same widths, directions and meanings as REQ-004..007, for requester B.
REQ-009 txdata  output  8  byte to the UART transmitter, registered.
REQ-010 send  output  1  transmit request to the UART transmitter, registered.
REQ-011 txdone  input  1  transmitter byte-complete flag; high after stop bit, low once a new byte starts.
REQ-012 owner  output  1  requester of the byte in flight (0=A, 1=B).
REQ-013 busy  output  1  high when state is not IDLE or either FIFO is non-empty.

Function
REQ-014 Each requester SHALL have a DEPTH-entry FIFO of {last, data}; push on valid&&ready; ready = !full; no pass-through.
REQ-015 A push into a full FIFO SHALL NOT occur; a push and a pop in the same cycle on a non-full FIFO SHALL both take effect.
REQ-016 FSM states: IDLE, START, WAIT, GAP.
REQ-017 IDLE: if lock=1, only the owner FIFO is eligible; else round-robin, the requester not served last wins when both are non-empty, the sole non-empty one otherwise; none eligible -> stay IDLE.
REQ-018 IDLE with a winner: on that edge pop its head, load txdata, set owner, send<=1, go START.
REQ-019 START: hold send=1 and txdata; on txdone==0 go WAIT; this ignores a stale txdone left high from the previous byte.
REQ-020 WAIT: hold send=1; on txdone==1, send<=0, go GAP.
REQ-021 GAP: send=0 for exactly one cycle, then IDLE.
REQ-022 Popped entry with last=0 SHALL set lock=1 (owner held); last=1 SHALL clear lock and record owner as last served.
REQ-023 A locked owner whose FIFO is empty SHALL keep lock; scheduler waits in IDLE, other requester is starved until the owner's last byte.
REQ-024 Byte pushed into an empty FIFO at edge N with scheduler idle and eligible SHALL see send=1 after edge N+1.
REQ-025 txdata and owner SHALL change only on the IDLE->START edge.
REQ-026 Minimum send-low time between bytes SHALL be one clock (GAP).

Reset
REQ-027 reset=0 SHALL immediately force send=0, txdata=0, owner=0, state=IDLE, lock=0, last-served=B (so A wins first), both FIFOs empty.
REQ-028 During reset, a_ready=b_ready=0; busy=0.
REQ-029 Reset mid-byte SHALL abandon the byte; no replay after release.
REQ-030 First push SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-031 State encoding (2-bit) and default DEPTH SHALL live in the shared UART include file used by the transmit path.
REQ-032 One sub-module, tx_fifo (parameter DEPTH, 9-bit entries, count-based full/empty), instantiated twice.
REQ-033 Arbiter and FSM SHALL be in tx_scheduler itself.

Verification
REQ-034 Single byte: A pushes 0x41 last=1 -> send rises one edge later, txdata=0x41, owner=0; model txdone low then high -> send falls, one cycle GAP, IDLE, busy=0.
REQ-035 Contention: A and B each push one last=1 byte (0x11, 0x22) same cycle after reset -> order 0x11 then 0x22; repeat -> alternation continues A,B.
REQ-036 Lock: A pushes 0x01,0x02 (last=0), B pushes 0x99, then A pushes 0x03 last=1 late -> output order 0x01,0x02,0x03,0x99; scheduler waits in IDLE for 0x03.
REQ-037 Full: DEPTH=4, A pushes 5 bytes with txdone held low -> a_ready=0 after 4 stored (one in flight); no data loss, all 5 transmitted in order.
REQ-038 Stale txdone: txdone held high before issue -> scheduler stays START until txdone=0, no premature GAP.
REQ-039 Reset in WAIT: reset=0 asynchronously -> send=0 same cycle, FIFOs empty, after release first byte goes out from A with owner=0.
